uart_tx_framer: RTL
===================

// Module: uart_tx_framer
// PURPOSE
//   Serialising UART transmit framer fed by the mod-103 baud divider's one-cycle terminal-count pulse.
//   Accepts parallel bytes over a VALID/READY handshake into a 1-entry holding register.
//   Emits start, data (LSB first), optional parity and stop bits, one bit per BAUD_TICK period.
//   Output TX drives the board pin; BUSY and DONE feed status logic and debug header J3.
// PARAMETERS
//   DATA_BITS   8  data bits per frame, legal range 5..8
//   PARITY_EN   0  1 = insert parity bit after the data bits
//   PARITY_ODD  0  1 = odd parity, 0 = even parity; ignored when PARITY_EN=0
//   STOP_BITS   1  stop bits per frame, legal range 1..2
// PORTS
//   CLKIN      in   1          system clock; all flops on the rising edge
//   RESETN     in   1          asynchronous active-low reset
//   BAUD_TICK  in   1          one-CLKIN-cycle pulse, once per bit period
//   DATA       in   DATA_BITS  byte to send; sampled only on handshake
//   VALID      in   1          producer offers DATA
//   READY      out  1          holding register empty; handshake = VALID & READY
//   TX         out  1          serial line, idle high; registered output
//   BUSY       out  1          frame in progress (state != IDLE); registered
//   DONE       out  1          1-cycle pulse on the tick that ends the last stop bit
// BEHAVIOUR
//   Reset (RESETN=0, async): TX=1, BUSY=0, DONE=0, READY=1, state=IDLE, holding register empty,
//     shift register and bit counter cleared. Deassertion is taken synchronously by the next CLKIN edge.
//   Handshake:
//     - READY = !hold_full, driven from a flop with no combinational path from VALID.
//     - VALID & READY at an edge: DATA -> hold, hold_full=1.
//     - VALID may drop without a handshake; no effect.
//   States: IDLE, START, DATA, PARITY, STOP. Transitions occur only on edges where BAUD_TICK=1.
//   Between ticks, state, TX and the counters hold their values.
//     - IDLE & hold_full & tick: TX<=0, shift<=hold, hold_full<=0, ->START.
//       Latency from handshake to start bit is 1..103 cycles, depending on tick phase.
//     - IDLE & tick & !hold_full: ignored; TX stays 1.
//     - START & tick: TX<=shift[0], shift>>=1, bitcnt<=1, ->DATA.
//     - DATA & tick:
//         if bitcnt<DATA_BITS: TX<=shift[0], bitcnt++.
//         else: TX<=parity and ->PARITY if PARITY_EN; otherwise TX<=1 and ->STOP.
//     - PARITY & tick: TX<=1, ->STOP.
//     - STOP & tick:
//         if stopcnt<STOP_BITS: stopcnt++, TX stays 1.
//         else: DONE=1 for this cycle, then:
//           hold_full -> TX<=0, reload shift, ->START (back-to-back, no idle bit);
//           otherwise -> IDLE, TX=1.
//   Parity: XOR of the DATA_BITS data bits, inverted when PARITY_ODD=1.
//     Computed from the captured byte at START load.
//   Bit period: exactly one tick interval for every bit, including start and stop.
//   Frame length: 1+DATA_BITS+PARITY_EN+STOP_BITS ticks.
//   Buffering and simultaneous events:
//     - Handshake is allowed while BUSY. A byte accepted mid-frame waits in hold.
//     - The hold drain (tick in IDLE or at end of STOP) and a handshake cannot coincide,
//       because READY=0 whenever hold is full.
//     - After a drain, READY returns to 1 on the following cycle.
//   Tick spacing: BAUD_TICK on consecutive cycles is legal; each tick advances one bit.
//   Reset mid-frame: frame aborts, TX=1 immediately (async), hold contents discarded.
//   bitcnt width: $clog2(DATA_BITS+1). No wrap: it is reset at START.
// TESTING
//   1. Reset, ticks every 103 cycles, send 8'hA5 (8N1) -> TX bits per tick 0,1,0,1,0,0,1,0,1,1.
//      DONE pulses once at tick 10; BUSY high for exactly 10 tick periods.
//   2. Back-to-back: send 8'h00, and 8'hFF during the first frame -> READY=0 until the second drain.
//      TX = 0 x9, 1, then 0, 1 x9 with no idle gap; two DONE pulses, 10 ticks apart.
//   3. PARITY_EN=1, PARITY_ODD=0, 8'h07 -> parity bit 1.
//      With PARITY_ODD=1 -> parity bit 0; frame is 11 ticks.
//   4. STOP_BITS=2, DATA_BITS=5, byte 5'h1F -> TX 0,1,1,1,1,1,1,1; DONE on the 8th tick.
//   5. Assert RESETN=0 during data bit 3 of 8'h3C with 8'h81 held -> TX=1, BUSY=0, READY=1 at once.
//      After release, no frame appears until a new handshake.
//   6. VALID pulsed with no tick for 500 cycles -> TX stays 1, BUSY=0, READY=0 (byte held).
//      The first tick then starts the frame.

Source files
------------

// File: rtl/uart_tx_framer.sv
// UART transmit framer: 1-entry holding register in front of a start/data/parity/stop serialiser.
// Every bit lasts exactly one BAUD_TICK interval; back-to-back frames leave no idle bit between them.
module uart_tx_framer #(
    parameter int DATA_BITS  = 8,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 CLKIN,
    input  logic                 RESETN,
    input  logic                 BAUD_TICK,
    input  logic [DATA_BITS-1:0] DATA,
    input  logic                 VALID,
    output logic                 READY,
    output logic                 TX,
    output logic                 BUSY,
    output logic                 DONE
);
    localparam int CNT_W = $clog2(DATA_BITS + 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_t;

    state_t               state_q, state_d;
    logic [DATA_BITS-1:0] hold_q, hold_d;
    logic                 hold_full_q, hold_full_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [CNT_W-1:0]     bitcnt_q, bitcnt_d;
    logic [1:0]           stopcnt_q, stopcnt_d;
    logic                 parity_q, parity_d;
    logic                 tx_q, tx_d;
    logic                 busy_q;
    logic                 done_q, done_d;
    logic                 drain;

    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        shift_d     = shift_q;
        bitcnt_d    = bitcnt_q;
        stopcnt_d   = stopcnt_q;
        parity_d    = parity_q;
        tx_d        = tx_q;
        done_d      = 1'b0;
        drain       = 1'b0;

        if (VALID && !hold_full_q) begin
            hold_d      = DATA;
            hold_full_d = 1'b1;
        end

        if (BAUD_TICK) begin
            case (state_q)
                ST_IDLE: begin
                    if (hold_full_q) begin
                        drain = 1'b1;
                    end
                end
                ST_START: begin
                    tx_d     = shift_q[0];
                    shift_d  = shift_q >> 1;
                    bitcnt_d = CNT_W'(1);
                    state_d  = ST_DATA;
                end
                ST_DATA: begin
                    if (bitcnt_q < CNT_W'(DATA_BITS)) begin
                        tx_d     = shift_q[0];
                        shift_d  = shift_q >> 1;
                        bitcnt_d = bitcnt_q + CNT_W'(1);
                    end else if (PARITY_EN != 0) begin
                        tx_d    = parity_q;
                        state_d = ST_PARITY;
                    end else begin
                        tx_d      = 1'b1;
                        stopcnt_d = 2'd1;
                        state_d   = ST_STOP;
                    end
                end
                ST_PARITY: begin
                    tx_d      = 1'b1;
                    stopcnt_d = 2'd1;
                    state_d   = ST_STOP;
                end
                ST_STOP: begin
                    if (stopcnt_q < 2'(STOP_BITS)) begin
                        stopcnt_d = stopcnt_q + 2'd1;
                    end else begin
                        done_d = 1'b1;
                        if (hold_full_q) begin
                            drain = 1'b1;
                        end else begin
                            tx_d    = 1'b1;
                            state_d = ST_IDLE;
                        end
                    end
                end
                default: begin
                    tx_d    = 1'b1;
                    state_d = ST_IDLE;
                end
            endcase
        end

        // A drain never coincides with a handshake: READY is low while hold is full.
        if (drain) begin
            tx_d        = 1'b0;
            shift_d     = hold_q;
            hold_full_d = 1'b0;
            parity_d    = (^hold_q) ^ (PARITY_ODD != 0);
            state_d     = ST_START;
        end
    end

    always_ff @(posedge CLKIN or negedge RESETN) begin
        if (!RESETN) begin
            state_q     <= ST_IDLE;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            shift_q     <= '0;
            bitcnt_q    <= '0;
            stopcnt_q   <= '0;
            parity_q    <= 1'b0;
            tx_q        <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            shift_q     <= shift_d;
            bitcnt_q    <= bitcnt_d;
            stopcnt_q   <= stopcnt_d;
            parity_q    <= parity_d;
            tx_q        <= tx_d;
            busy_q      <= (state_d != ST_IDLE);
            done_q      <= done_d;
        end
    end

    assign READY = !hold_full_q;
    assign TX    = tx_q;
    assign BUSY  = busy_q;
    assign DONE  = done_q;

endmodule
